rd_stream_adapter: RTL and testbench
====================================

RD_STREAM_ADAPTER -- requirements
Module: rd_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of a FIFO word and of the stream data.
REQ-002 SHALL have parameter BURST_LEN, default 4, giving the number of beats per burst (2..255).
REQ-003 SHALL have port r_clk, input, 1 bit: the single clock, which is the FIFO read-domain clock.
REQ-004 SHALL have port rrst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: enables draining of the FIFO.
REQ-006 SHALL have port fifo_empty, input, 1 bit: the FIFO empty flag.
REQ-007 SHALL have port data_out, input, DATA_W bits: the FIFO read data.
REQ-008 SHALL have port rd_req, output, 1 bit: the FIFO read request.
REQ-009 SHALL have port m_data, output, DATA_W bits: the stream data.
REQ-010 SHALL have port m_valid, output, 1 bit: the stream beat is valid.
REQ-011 SHALL have port m_ready, input, 1 bit: the sink accepts the beat.
REQ-012 SHALL have port m_last, output, 1 bit: the current beat is the final beat of a burst.
REQ-013 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-014 SHALL have port beat_cnt, output, 16 bits: total beats accepted, wrapping.

Function
REQ-015 SHALL treat the FIFO read latency as fixed: data_out is valid exactly 1 cycle after a cycle with rd_req=1.
REQ-016 SHALL hold returned words in a 2-entry output buffer, with m_data/m_valid always presenting the oldest entry.
REQ-017 SHALL assert rd_req only when all of: state is ACTIVE, fifo_empty=0, and (buffer occupancy + in-flight reads) < 2.
REQ-018 SHALL count a beat as transferred only in a cycle where m_valid=1 and m_ready=1.
REQ-019 SHALL keep m_data stable and keep m_valid asserted while m_valid=1 and m_ready=0.
REQ-020 SHALL, on a simultaneous buffer write (returning data) and pop (transfer), keep occupancy unchanged and preserve order.
REQ-021 SHALL drive m_last=1 on the beat whose burst index equals BURST_LEN-1.
REQ-022 SHALL advance the burst index only on a transfer, and SHALL wrap it to 0 after BURST_LEN-1.
REQ-023 SHALL increment beat_cnt by 1 per transfer, with 0xFFFF+1 giving 0.
REQ-024 SHALL implement FSM state IDLE -> ACTIVE when en=1.
REQ-025 SHALL implement FSM state ACTIVE -> DRAIN when en=0.
REQ-026 SHALL implement FSM state DRAIN -> IDLE when buffer occupancy = 0 and no read is in flight.
REQ-027 SHALL implement FSM state DRAIN -> ACTIVE when en=1.
REQ-028 SHALL issue no rd_req in DRAIN, and SHALL still deliver in-flight and buffered words in DRAIN.
REQ-029 SHALL, when fifo_empty=1, issue no new rd_req, and SHALL still deliver data already in flight.
REQ-030 SHALL leave the burst index untouched by en changes, so that a burst spans pauses.

Reset
REQ-031 SHALL, on rrst=1 sampled at a r_clk edge, set state=IDLE.
REQ-032 SHALL, on rrst=1 sampled at a r_clk edge, set rd_req=0, m_valid=0, m_last=0, busy=0, m_data=0, beat_cnt=0, burst index=0, and occupancy=0.
REQ-033 SHALL discard any in-flight read on reset mid-operation, with no beat presented afterwards for it.
REQ-034 SHALL use rrst as the only reset, with no asynchronous reset paths.

Structure
REQ-035 SHALL take the FSM state enum (IDLE, ACTIVE, DRAIN) and the default DATA_W/BURST_LEN constants from the shared FIFO package.
REQ-036 SHALL implement the 2-entry output buffer as a sub-module named skid_buf2, with push/pop/occupancy ports.
REQ-037 SHALL instantiate the block in the top design on the read side of Async_FIFO, sharing r_clk and rrst.

Verification
REQ-038 SHALL cover: 8 words (0x01..0x08) pre-loaded, en=1, m_ready=1 -> beats 0x01..0x08 in order, m_last on 0x04 and 0x08, beat_cnt=8.
REQ-039 SHALL cover: m_ready=0 for 5 cycles mid-stream -> rd_req stops once occupancy+in-flight=2, m_data held, no word lost or duplicated.
REQ-040 SHALL cover: FIFO holding 1 word then empty -> exactly 1 rd_req, 1 beat, then rd_req=0 while fifo_empty=1.
REQ-041 SHALL cover: en dropped with 2 words buffered -> DRAIN, 2 beats delivered, then IDLE and busy=0, and no rd_req after en=0.
REQ-042 SHALL cover: rrst asserted 1 cycle after rd_req -> next cycle m_valid=0, beat_cnt=0, state IDLE, and the returned word is not presented.
REQ-043 SHALL cover: beat_cnt preloaded via 65535 transfers, then one more transfer -> beat_cnt=0.

Source files
------------

// File: rtl/rd_stream_adapter_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: state encoding,
// default widths and the burst-index wrap helper.
package rd_stream_adapter_pkg;

   localparam int unsigned FIFO_DATA_W    = 8;
   localparam int unsigned FIFO_BURST_LEN = 4;
   localparam int unsigned BEAT_CNT_W     = 16;
   localparam int unsigned BURST_IDX_W    = 8;
   localparam int unsigned OCC_W          = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } rd_state_e;

   // Successor of a burst index, returning to zero after the final beat.
   function automatic logic [BURST_IDX_W-1:0] burst_idx_next(
      input logic [BURST_IDX_W-1:0] idx,
      input logic [BURST_IDX_W-1:0] last_idx
   );
      return (idx == last_idx) ? '0 : idx + BURST_IDX_W'(1);
   endfunction

endpackage

// File: rtl/rd_stream_adapter_skid.sv
// Two-entry in-order output buffer; head_o always shows the oldest entry.
module skid_buf2
   import rd_stream_adapter_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [OCC_W-1:0]  occ_o
);

   logic [DATA_W-1:0] ent0_q, ent0_d;
   logic [DATA_W-1:0] ent1_q, ent1_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              push_ok;
   logic              pop_ok;

   always_comb begin
      pop_ok  = pop_i && (occ_q != '0);
      // A full buffer only takes a word when the head leaves in the same cycle.
      push_ok = push_i && ((occ_q != OCC_W'(2)) || pop_ok);
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      occ_d   = occ_q;
      case ({push_ok, pop_ok})
         2'b10: begin
            if (occ_q == '0) ent0_d = push_data_i;
            else             ent1_d = push_data_i;
            occ_d = occ_q + OCC_W'(1);
         end
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - OCC_W'(1);
         end
         2'b11: begin
            if (occ_q == OCC_W'(1)) begin
               ent0_d = push_data_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign head_o = ent0_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/rd_stream_adapter.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream with
// burst framing (m_last) and a wrapping accepted-beat counter.
module rd_stream_adapter
   import rd_stream_adapter_pkg::*;
#(
   parameter int unsigned DATA_W    = FIFO_DATA_W,
   parameter int unsigned BURST_LEN = FIFO_BURST_LEN
) (
   input  logic                  r_clk,
   input  logic                  rrst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_W-1:0]     data_out,
   output logic                  rd_req,
   output logic [DATA_W-1:0]     m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic [BEAT_CNT_W-1:0] beat_cnt
);

   localparam logic [BURST_IDX_W-1:0] LAST_IDX = BURST_IDX_W'(BURST_LEN - 1);

   rd_state_e               state_q, state_d;
   logic                    inflight_q, inflight_d;
   logic [BURST_IDX_W-1:0]  burst_idx_q, burst_idx_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [OCC_W-1:0]        occ;
   logic [OCC_W-1:0]        pending;
   logic                    xfer;

   skid_buf2 #(.DATA_W(DATA_W)) u_buf (
      .clk_i       (r_clk),
      .rst_i       (rrst),
      .push_i      (inflight_q),
      .push_data_i (data_out),
      .pop_i       (xfer),
      .head_o      (m_data),
      .occ_o       (occ)
   );

   // Words already owned by the adapter: buffered plus the one on its way back.
   assign pending = occ + OCC_W'(inflight_q);
   assign m_valid = (occ != '0);
   assign xfer    = m_valid && m_ready;
   assign rd_req  = (state_q == ACTIVE) && !fifo_empty && (pending < OCC_W'(2));
   assign m_last  = m_valid && (burst_idx_q == LAST_IDX);
   assign busy    = (state_q != IDLE);
   assign beat_cnt = beat_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = ACTIVE;
         ACTIVE:  if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)                                state_d = ACTIVE;
            else if ((occ == '0) && !inflight_q)   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      inflight_d  = rd_req;
      burst_idx_d = xfer ? burst_idx_next(burst_idx_q, LAST_IDX) : burst_idx_q;
      beat_cnt_d  = beat_cnt_q + BEAT_CNT_W'(xfer);
   end

   // Clearing inflight_q on reset drops a read whose data is still returning.
   always_ff @(posedge r_clk) begin
      if (rrst) begin
         state_q     <= IDLE;
         inflight_q  <= 1'b0;
         burst_idx_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         burst_idx_q <= burst_idx_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Directed bench for rd_stream_adapter with a queue-based FIFO and stream model.
module tb_rd_stream_adapter;

   localparam int DW = 8;
   localparam int BL = 4;

   logic          r_clk = 1'b0;
   logic          rrst, en, fifo_empty, m_ready;
   logic [DW-1:0] data_out, m_data;
   logic          rd_req, m_valid, m_last, busy;
   logic [15:0]   beat_cnt;

   always #5 r_clk = ~r_clk;

   rd_stream_adapter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
      .r_clk(r_clk), .rrst(rrst), .en(en), .fifo_empty(fifo_empty),
      .data_out(data_out), .rd_req(rd_req), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .busy(busy), .beat_cnt(beat_cnt)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // FIFO environment
   logic [DW-1:0] fifo_q[$];
   bit            env_infl;
   // stream model: words handed back by the FIFO and not yet accepted
   logic [DW-1:0] buf_q[$];
   bit            mdl_ok, mdl_active, mdl_busy;
   int            mdl_nxfer;
   logic [15:0]   mdl_cnt;
   // observation logs
   logic [DW-1:0] acc_q[$];
   bit            last_q[$];
   int            rdreq_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: compare at negedge, advance model and FIFO after posedge.
   task automatic step();
      logic [DW-1:0] nxt_data;
      bit            nxt_infl, xfer, exp_rd, exp_v;
      int            occ;
      @(negedge r_clk);
      occ    = buf_q.size();
      exp_v  = occ > 0;
      exp_rd = mdl_active && (fifo_q.size() > 0) && ((occ + int'(env_infl)) < 2);
      if (mdl_ok) begin
         chk("rd_req", rd_req, exp_rd);
         chk("m_valid", m_valid, exp_v);
         if (exp_v) chk("m_data", m_data, buf_q[0]);
         chk("m_last", m_last, exp_v && ((mdl_nxfer % BL) == BL - 1));
         chk("busy", busy, mdl_busy);
         chk("beat_cnt", beat_cnt, mdl_cnt);
      end
      if (m_valid && m_ready) begin
         acc_q.push_back(m_data);
         last_q.push_back(m_last);
      end
      if (rd_req) rdreq_seen++;
      nxt_infl = 1'b0;
      nxt_data = 8'hEE;
      if (rrst) begin
         fifo_q.delete();
         buf_q.delete();
         mdl_active = 1'b0;
         mdl_busy   = 1'b0;
         mdl_nxfer  = 0;
         mdl_cnt    = 16'h0;
         mdl_ok     = 1'b1;
      end else begin
         if (rd_req && fifo_q.size() > 0) begin
            nxt_data = fifo_q.pop_front();
            nxt_infl = 1'b1;
         end
         xfer       = exp_v && m_ready;
         mdl_busy   = en || mdl_active || (mdl_busy && ((occ + int'(env_infl)) != 0));
         mdl_active = en;
         if (xfer) begin
            void'(buf_q.pop_front());
            mdl_nxfer++;
            mdl_cnt = mdl_cnt + 16'h1;
         end
         if (env_infl) buf_q.push_back(data_out);
      end
      @(posedge r_clk);
      #1;
      env_infl   = nxt_infl;
      data_out   = nxt_data;
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic load(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic wait_acc(input string name, input int n, input int budget);
      for (int k = 0; k < budget && acc_q.size() < n; k++) step();
      chk(name, acc_q.size(), n);
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int k = 0; k < budget && busy; k++) step();
      chk(name, busy, 1'b0);
   endtask

   initial begin
      rrst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
      data_out = 8'hEE; env_infl = 1'b0;
      mdl_ok = 1'b0; mdl_active = 1'b0; mdl_busy = 1'b0; mdl_nxfer = 0; mdl_cnt = 16'h0;
      rdreq_seen = 0;
      steps(2);
      rrst = 1'b0;
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_rd_req", rd_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_m_data", m_data, 8'h00);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_beat_cnt", beat_cnt, 16'h0);

      // eight words straight through, two bursts of four
      for (int i = 1; i <= 8; i++) load(DW'(i));
      en = 1'b1; m_ready = 1'b1;
      wait_acc("t1_count", 8, 40);
      for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
         chk("t1_word", acc_q[i], i + 1);
         chk("t1_last", last_q[i], (i == 3 || i == 7));
      end
      chk("t1_beat_cnt", beat_cnt, 16'd8);
      en = 1'b0;
      wait_idle("t1_idle", 10);

      // sink stall mid-stream
      acc_q.delete(); last_q.delete();
      for (int i = 0; i < 8; i++) load(8'h10 + DW'(i));
      en = 1'b1;
      steps(4);
      m_ready = 1'b0;
      steps(2);
      rdreq_seen = 0;
      steps(3);
      chk("t2_stall_rdreq", rdreq_seen, 0);
      m_ready = 1'b1;
      wait_acc("t2_count", 8, 60);
      for (int i = 0; i < 8 && i < acc_q.size(); i++) chk("t2_word", acc_q[i], 8'h10 + i);
      chk("t2_beat_cnt", beat_cnt, 16'd16);

      // single word, then an empty FIFO
      acc_q.delete(); last_q.delete();
      rdreq_seen = 0;
      load(8'hA5);
      steps(10);
      chk("t3_rdreq_pulses", rdreq_seen, 1);
      chk("t3_count", acc_q.size(), 1);
      if (acc_q.size() > 0) chk("t3_word", acc_q[0], 8'hA5);
      chk("t3_rd_req_idle", rd_req, 1'b0);
      chk("t3_beat_cnt", beat_cnt, 16'd17);

      // en dropped with two words buffered
      acc_q.delete(); last_q.delete();
      m_ready = 1'b0;
      load(8'hB1); load(8'hB2); load(8'hB3);
      steps(5);
      en = 1'b0;
      rdreq_seen = 0;
      steps(3);
      chk("t4_busy_drain", busy, 1'b1);
      m_ready = 1'b1;
      wait_idle("t4_idle", 10);
      chk("t4_rdreq_after_en", rdreq_seen, 0);
      chk("t4_count", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         chk("t4_word0", acc_q[0], 8'hB1);
         chk("t4_word1", acc_q[1], 8'hB2);
      end
      chk("t4_beat_cnt", beat_cnt, 16'd19);
      fifo_q.delete();
      fifo_empty = 1'b1;

      // reset one cycle after a read request
      acc_q.delete(); last_q.delete();
      en = 1'b1;
      load(8'hC1); load(8'hC2);
      rdreq_seen = 0;
      for (int k = 0; k < 10 && rdreq_seen == 0; k++) step();
      chk("t5_rdreq_issued", rdreq_seen, 1);
      rrst = 1'b1; en = 1'b0;
      step();
      rrst = 1'b0;
      chk("t5_m_valid", m_valid, 1'b0);
      chk("t5_beat_cnt", beat_cnt, 16'h0);
      chk("t5_busy", busy, 1'b0);
      steps(3);
      chk("t5_no_stale_beat", acc_q.size(), 0);
      chk("t5_m_valid_late", m_valid, 1'b0);

      // counter wrap: start near the top of the range, then transfer through it
      force dut.beat_cnt_q = 16'hFFFD;
      mdl_cnt = 16'hFFFD;
      step();
      release dut.beat_cnt_q;
      acc_q.delete(); last_q.delete();
      load(8'hD1); load(8'hD2); load(8'hD3);
      en = 1'b1; m_ready = 1'b1;
      wait_acc("t6_count", 3, 30);
      chk("t6_beat_cnt_wrap", beat_cnt, 16'h0000);
      en = 1'b0;
      wait_idle("t6_idle", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
